pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 16-bit CPU. It drives the PC write enable, the IF/ID stall and flush controls, the ID/EX bubble insert and the EX/MEM hold. It detects load-use hazards and taken branches resolved in EX, and sequences multi-cycle stall and flush windows with a down-counter. A data-memory busy signal freezes the whole front end.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a memory-busy freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 3,
    parameter int LU_CYCLES    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int ZERO_REG_HW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             stall_ex,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]      perf_stall_cnt,
    output logic [15:0]      perf_flush_cnt
`endif
);

    localparam int MAX_CYC = (LU_CYCLES > FLUSH_CYCLES) ? LU_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lu;
    logic               rd_is_zero;
    logic               rs1_hit;
    logic               rs2_hit;

    // A load into a hardwired r0 writes nothing, so it can never create a dependency.
    assign rd_is_zero = (ZERO_REG_HW != 0) && (ex_rd == '0);
    assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu         = ex_is_load && !rd_is_zero && (rs1_hit || rs2_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_we     = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        stall_ex  = 1'b0;

        if (rst) begin
            // Keep NOPs flowing into IF/ID and ID/EX while the core is held in reset.
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe holds; EX keeps its instruction so branch/lu re-present later.
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // ID holds a wrong-path instruction, so any lu match is moot.
                        pc_we     = 1'b1;
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (lu) begin
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        if (LU_CYCLES > 1) begin
                            state_d = ST_LU;
                            cnt_d   = CNT_W'(LU_CYCLES - 1);
                        end
                    end else begin
                        pc_we = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    pc_we     = 1'b1;
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_LU: begin
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_id && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
        if (flush_id && !rst && (perf_flush_q != 16'hFFFF)) begin
            perf_flush_d = perf_flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with different stall/flush
// lengths share one stimulus stream and are checked against hand-derived outputs.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken, mem_busy;

    logic       pc_we_a, stall_id_a, flush_id_a, bubble_ex_a, stall_ex_a;
    logic       pc_we_b, stall_id_b, flush_id_b, bubble_ex_b, stall_ex_b;
    logic       pc_we_c, stall_id_c, flush_id_c, bubble_ex_c, stall_ex_c;
    logic [1:0] st_a, st_b, st_c;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] ps_a, pf_a, ps_b, pf_b, ps_c, pf_c;
`endif

    int checks = 0;
    int errors = 0;

    // Output vector order: {pc_we, stall_id, flush_id, bubble_ex, stall_ex}
    localparam logic [4:0] RUN_O = 5'b10000;
    localparam logic [4:0] LU_O  = 5'b01010;
    localparam logic [4:0] FL_O  = 5'b10110;
    localparam logic [4:0] FRZ_O = 5'b01001;
    localparam logic [4:0] RST_O = 5'b00110;

    wire [4:0] o_a = {pc_we_a, stall_id_a, flush_id_a, bubble_ex_a, stall_ex_a};
    wire [4:0] o_b = {pc_we_b, stall_id_b, flush_id_b, bubble_ex_b, stall_ex_b};
    wire [4:0] o_c = {pc_we_c, stall_id_c, flush_id_c, bubble_ex_c, stall_ex_c};

    pipe_hazard_ctrl #(.REG_W(3), .LU_CYCLES(1), .FLUSH_CYCLES(1), .ZERO_REG_HW(1)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_we(pc_we_a), .stall_id(stall_id_a), .flush_id(flush_id_a),
        .bubble_ex(bubble_ex_a), .stall_ex(stall_ex_a), .ctrl_state(st_a)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(ps_a), .perf_flush_cnt(pf_a)
`endif
    );

    pipe_hazard_ctrl #(.REG_W(3), .LU_CYCLES(2), .FLUSH_CYCLES(2), .ZERO_REG_HW(1)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_we(pc_we_b), .stall_id(stall_id_b), .flush_id(flush_id_b),
        .bubble_ex(bubble_ex_b), .stall_ex(stall_ex_b), .ctrl_state(st_b)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(ps_b), .perf_flush_cnt(pf_b)
`endif
    );

    pipe_hazard_ctrl #(.REG_W(3), .LU_CYCLES(3), .FLUSH_CYCLES(3), .ZERO_REG_HW(1)) dut_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_we(pc_we_c), .stall_id(stall_id_c), .flush_id(flush_id_c),
        .bubble_ex(bubble_ex_c), .stall_ex(stall_ex_c), .ctrl_state(st_c)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(ps_c), .perf_flush_cnt(pf_c)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [4:0] ea, input logic [1:0] sa,
                           input logic [4:0] eb, input logic [1:0] sb,
                           input logic [4:0] ec, input logic [1:0] sc);
        chk({tag, ".a.out"}, {11'd0, o_a}, {11'd0, ea});
        chk({tag, ".a.st"},  {14'd0, st_a}, {14'd0, sa});
        chk({tag, ".b.out"}, {11'd0, o_b}, {11'd0, eb});
        chk({tag, ".b.st"},  {14'd0, st_b}, {14'd0, sb});
        chk({tag, ".c.out"}, {11'd0, o_c}, {11'd0, ec});
        chk({tag, ".c.st"},  {14'd0, st_c}, {14'd0, sc});
        $display("step %-14s a=%b/%0d b=%b/%0d c=%b/%0d", tag, o_a, st_a, o_b, st_b, o_c, st_c);
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                          input logic u2, input logic [2:0] rd, input logic ld,
                          input logic br, input logic busy);
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_rd = rd; ex_is_load = ld; ex_branch_taken = br; mem_busy = busy;
    endtask

    task automatic idle();
        set_in(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk_all("rst0", RST_O, 2'd0, RST_O, 2'd0, RST_O, 2'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            chk_all($sformatf("rst%0d", i), RST_O, 2'd0, RST_O, 2'd0, RST_O, 2'd0);
        end
        tick(); rst = 1'b0; #1;
        chk_all("release", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);

        // Load-use on rs1 for a single cycle.
        tick(); set_in(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0); #1;
        chk_all("lu.c0", LU_O, 2'd0, LU_O, 2'd0, LU_O, 2'd0);
        tick(); idle(); #1;
        chk_all("lu.c1", RUN_O, 2'd0, LU_O, 2'd1, LU_O, 2'd1);
        tick(); #1;
        chk_all("lu.c2", RUN_O, 2'd0, RUN_O, 2'd0, LU_O, 2'd1);
        tick(); #1;
        chk_all("lu.c3", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf.stall.a", ps_a, 16'd1);
        chk("perf.stall.b", ps_b, 16'd2);
        chk("perf.stall.c", ps_c, 16'd3);
        chk("perf.flush.b", pf_b, 16'd0);
`endif

        // Load to hardwired r0: no hazard.
        tick(); set_in(3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0); #1;
        chk_all("lu.r0", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);
        // rs1 matches but is unused; rs2 used but differs: no hazard.
        tick(); set_in(3'd5, 1'b0, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0); #1;
        chk_all("lu.nouse", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);
        // Non-load writing a matching register: no hazard.
        tick(); set_in(3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0); #1;
        chk_all("lu.noload", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);
        // Hazard through rs2.
        tick(); set_in(3'd5, 1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0); #1;
        chk_all("lu.rs2", LU_O, 2'd0, LU_O, 2'd0, LU_O, 2'd0);
        tick(); idle(); #1;
        chk_all("lu.rs2.c1", RUN_O, 2'd0, LU_O, 2'd1, LU_O, 2'd1);
        tick(); tick(); #1;
        chk_all("lu.rs2.done", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);

        // Taken branch with a simultaneous load-use match: flush wins.
        tick(); set_in(3'd4, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0); #1;
        chk_all("br.c0", FL_O, 2'd0, FL_O, 2'd0, FL_O, 2'd0);
        tick(); set_in(3'd4, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0); #1;
        // FLUSH ignores both ex_* events; A is back in RUN and sees the branch again.
        chk_all("br.c1", FL_O, 2'd0, FL_O, 2'd2, FL_O, 2'd2);
        tick(); idle(); #1;
        chk_all("br.c2", RUN_O, 2'd0, RUN_O, 2'd0, FL_O, 2'd2);
        tick(); #1;
        chk_all("br.c3", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf.flush.a", pf_a, 16'd2);
        chk("perf.flush.b", pf_b, 16'd2);
        chk("perf.flush.c", pf_c, 16'd3);
`endif

        // mem_busy for 4 cycles in the middle of a load-use window.
        tick(); set_in(3'd6, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0); #1;
        chk_all("mb.c0", LU_O, 2'd0, LU_O, 2'd0, LU_O, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            tick(); set_in(3'd6, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1, 1'b1); #1;
            chk_all($sformatf("mb.frz%0d", i), FRZ_O, 2'd0, FRZ_O, 2'd1, FRZ_O, 2'd1);
        end
        tick(); idle(); #1;
        chk_all("mb.r1", RUN_O, 2'd0, LU_O, 2'd1, LU_O, 2'd1);
        tick(); #1;
        chk_all("mb.r2", RUN_O, 2'd0, RUN_O, 2'd0, LU_O, 2'd1);
        tick(); #1;
        chk_all("mb.r3", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);

        // Asynchronous reset pulsed in the middle of a flush window.
        tick(); set_in(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0); #1;
        chk_all("rf.c0", FL_O, 2'd0, FL_O, 2'd0, FL_O, 2'd0);
        tick(); idle(); #1;
        chk_all("rf.c1", RUN_O, 2'd0, FL_O, 2'd2, FL_O, 2'd2);
        rst = 1'b1; #1;
        chk_all("rf.rst", RST_O, 2'd0, RST_O, 2'd0, RST_O, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf.clr.c", ps_c, 16'd0);
`endif
        tick(); rst = 1'b0; #1;
        chk_all("rf.after", RUN_O, 2'd0, RUN_O, 2'd0, RUN_O, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
